xdisp_scan: RTL and testbench
=============================

# xdisp_scan

Parametrised, memory-mapped multiplexed seven-segment display controller for the calculator SoC. It accepts a binary value, sign, dot and message mode from the controller data bus and converts the value to BCD with a sequential double-dabble engine. It blanks leading zeros, detects overflow and time-multiplexes N common-anode digits. It sits on the address decoder as a write-only peripheral, driving the board `Disp`/`Disp_sel` pins, and generalises the fixed 4-digit, 8-bit display decoder.

## Interface
- `N_DIGITS`, 4: number of digits, legal range 3..8. Digit 0 is rightmost.
- `BIN_W`, 8: magnitude width. Must satisfy 2^BIN_W < 10^(N_DIGITS+1).
- `SCAN_DIV`, 50000: clk cycles each digit is held, minimum 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `sel` in 1: peripheral select from the address decoder.
- `we` in 1: bus write enable.
- `data_in` in BIN_W: unsigned magnitude to display.
- `msg` in 2: display mode. 00 number, 01 "OP", 10 "UAL" (VAL), 11 "Err".
- `sgn` in 1: 1 means show the minus sign.
- `dot` in N_DIGITS: dot[i]=1 lights the decimal point of digit i.
- `busy` out 1: conversion in progress. Writes are ignored while high.
- `disp_value` out 8: segments {dp,g,f,e,d,c,b,a}, active-low.
- `disp_select` out N_DIGITS: digit enable, one-hot active-low.

## Operation
- Accepted write: `sel & we & ~busy` at a rising edge. On that edge the block latches `data_in`, `msg`, `sgn` and `dot` into input registers.
- Conversion FSM has three states:
  - IDLE: waits for an accepted write, then goes to CONV with the bit counter at 0.
  - CONV: BIN_W cycles of shift-and-add-3 over a (N_DIGITS+1)-digit BCD register.
  - LOAD: 1 cycle. Writes the glyph codes of all digits into the shadow register, then goes to IDLE.
- In non-number modes the FSM runs the same states, giving uniform latency. The BCD result is discarded.
- Overflow: if `msg`=00 and the magnitude is ≥ 10^(N_DIGITS−sgn), the display shows Err.
- Number mode layout:
  - Leading zeros are blanked. Digit 0 is always shown, including for value 0.
  - If `sgn`=1, '-' goes in the digit immediately left of the most significant shown digit.
- Message layout: digits 2..0 show E,r,r (Err) or U,A,L (VAL). OP uses digits 1..0. All other digits are blank.
- A `dot` bit clears dp on its digit in every mode, including Err.
- Glyphs (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, '-'=BF, blank=FF, E=86, r=AF, O=C0, P=8C, U=C1, A=88, L=C7. The dp bit is bit 7, applied as AND with ~dot[i].
- Scanner:
  - The prescaler counts 0..SCAN_DIV−1. On wrap, the digit index advances and wraps from N_DIGITS−1 to 0.
  - `disp_select[idx]`=0, all other bits 1. `disp_value` = shadow[idx].
  - Both outputs are registered, so they change on the same edge.
- The shadow register updates atomically in LOAD. The old content stays displayed during CONV.
- Writes with `busy`=1 are dropped entirely. They are not queued and do not restart the conversion.

## Timing
- Reset values:
  - `busy`=0, FSM=IDLE, prescaler=0, digit index=0.
  - Shadow all FF (blank), `disp_select` all 1, `disp_value`=FF.
- Scanning starts on the first edge after reset release. `disp_select` becomes ...1110 after SCAN_DIV cycles.
- Write accepted at edge T:
  - `busy`=1 from T through T+BIN_W+1.
  - Shadow updated at edge T+BIN_W+1.
  - `busy`=0 after edge T+BIN_W+1.
- Earliest next accepted write is at edge T+BIN_W+2.
- The new shadow value appears on the pins at the next digit-advance edge, or on the same edge if that edge is also the LOAD edge.
- Full refresh period is N_DIGITS×SCAN_DIV cycles.
- Reset asserted mid-conversion aborts immediately. All state returns to reset values and the display blanks.
- `sel` without `we` has no effect. Reads are not supported; the decoder returns 0 for this address.

## Test plan
- Reset and scan, SCAN_DIV=4, N=4: release reset, no writes. `disp_select` cycles 1110→1101→1011→0111→1110 every 4 clocks, and `disp_value`=FF throughout.
- Number conversion: write 8'd205, msg=00, sgn=0, dot=0.
  - `busy` is high for 9 cycles.
  - Digits 3..0 show FF, A4, C0, 92 ("205" with the leading digit blank).
- Sign and dot: write 7, sgn=1, dot=0001. Digit 1 shows BF, digit 0 shows 78 (7 with dp), digits 3..2 show FF.
- Overflow: N=3, BIN_W=10, write 1000 with sgn=0 → digits 2..0 show 86, AF, AF. Then write 100 with sgn=1 → Err.
- Messages: msg=01 → digits 1..0 show C0, 8C and the rest FF. msg=10 → digits 2..0 show C1, 88, C7.
- Busy and reset: write 42, then write 99 two cycles later. The second write is ignored and the display shows 42. Write again and pull `rst` low during CONV. Outputs are immediately FF/all-1 and `busy`=0.

Source files
------------

// File: rtl/xdisp_scan.sv
// Multiplexed seven-segment display controller: latches a write, converts the
//   magnitude to BCD by double-dabble, builds per-digit glyphs and scans N digits.
// Latency: shadow updated BIN_W+1 cycles after the accepted write; writes
//   while busy are dropped (no queueing).
// Ports: clk/rst (async active-low); sel/we/data_in/msg/sgn/dot bus write side;
//   busy status; disp_value {dp,g..a} and disp_select one-hot, both active-low.
module xdisp_scan #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                we,
  input  logic [BIN_W-1:0]    data_in,
  input  logic [1:0]          msg,
  input  logic                sgn,
  input  logic [N_DIGITS-1:0] dot,
  output logic                busy,
  output logic [7:0]          disp_value,
  output logic [N_DIGITS-1:0] disp_select
);

  localparam int BCD_W = 4 * (N_DIGITS + 1);
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0]    sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_tmp;
  logic [1:0]          msg_q, msg_d;
  logic                sgn_q, sgn_d;
  logic [N_DIGITS-1:0] dot_q, dot_d;
  logic [7:0]          shadow_q [N_DIGITS];
  logic [7:0]          shadow_d [N_DIGITS];
  logic [7:0]          glyph    [N_DIGITS];
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] dsel_q, dsel_d;
  logic [7:0]          dval_q, dval_d;
  logic                ovf;
  int                  msd;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Glyph builder, evaluated from the finished BCD register during LOAD.
  // Overflow is read off the BCD digits: value >= 10^N means the extra top
  // digit is nonzero; with a sign the limit drops to 10^(N-1).
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) glyph[i] = 8'hFF;
    msd = 0;
    ovf = (bcd_q[4*N_DIGITS +: 4] != 4'd0) ||
          (sgn_q && (bcd_q[4*(N_DIGITS-1) +: 4] != 4'd0));
    if (msg_q == 2'b00 && !ovf) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      for (int i = 0; i < N_DIGITS; i++) begin
        if (i <= msd)                    glyph[i] = seg7(bcd_q[4*i +: 4]);
        else if (sgn_q && i == msd + 1)  glyph[i] = 8'hBF;
      end
    end else if (msg_q == 2'b01) begin
      glyph[1] = 8'hC0;
      glyph[0] = 8'h8C;
    end else if (msg_q == 2'b10) begin
      glyph[2] = 8'hC1;
      glyph[1] = 8'h88;
      glyph[0] = 8'hC7;
    end else begin
      glyph[2] = 8'h86;
      glyph[1] = 8'hAF;
      glyph[0] = 8'hAF;
    end
    for (int i = 0; i < N_DIGITS; i++) glyph[i][7] = glyph[i][7] & ~dot_q[i];
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    bcd_d    = bcd_q;
    msg_d    = msg_q;
    sgn_d    = sgn_q;
    dot_d    = dot_q;
    bcd_tmp  = bcd_q;
    shadow_d = shadow_q;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (sel && we) begin
          sh_d    = data_in;
          msg_d   = msg;
          sgn_d   = sgn;
          dot_d   = dot;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i <= N_DIGITS; i++) begin
          if (bcd_tmp[4*i +: 4] >= 4'd5) bcd_tmp[4*i +: 4] = bcd_tmp[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_tmp[BCD_W-2:0], sh_q[BIN_W-1]};
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) state_d = LOAD;
      end
      LOAD: begin
        shadow_d = glyph;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner: outputs reload only on prescaler wrap, taking the digit at the
  // current index before it advances. Reading shadow_d lets a LOAD that
  // coincides with the wrap reach the pins on the same edge.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    dsel_d  = dsel_q;
    dval_d  = dval_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      dsel_d  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      dval_d  = shadow_d[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      msg_q   <= 2'b00;
      sgn_q   <= 1'b0;
      dot_q   <= '0;
      for (int i = 0; i < N_DIGITS; i++) shadow_q[i] <= 8'hFF;
      presc_q <= '0;
      idx_q   <= '0;
      dsel_q  <= '1;
      dval_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bcd_q    <= bcd_d;
      msg_q    <= msg_d;
      sgn_q    <= sgn_d;
      dot_q    <= dot_d;
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      dsel_q   <= dsel_d;
      dval_q   <= dval_d;
    end
  end

  assign disp_value  = dval_q;
  assign disp_select = dsel_q;

endmodule

// File: tb/tb_xdisp_scan.sv
// Bench for xdisp_scan: instance A (4 digits, 8 bit) checked every cycle
//   against a behavioural model; instance B (3 digits, 10 bit) covers overflow.
// Directed literal digit expectations pin the model.
module tb_xdisp_scan;
  localparam int NA = 4, WA = 8,  SA = 4;
  localparam int NB = 3, WB = 10, SB = 2;
  localparam logic [7:0] DIG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, sel_a, we_a, sgn_a, busy_a;
  logic [WA-1:0] data_a;
  logic [1:0]    msg_a;
  logic [NA-1:0] dot_a, dsel_a;
  logic [7:0]    val_a;

  logic          rst_b, sel_b, we_b, sgn_b, busy_b;
  logic [WB-1:0] data_b;
  logic [1:0]    msg_b;
  logic [NB-1:0] dot_b, dsel_b;
  logic [7:0]    val_b;

  int total = 0;
  int bad   = 0;

  xdisp_scan #(.N_DIGITS(NA), .BIN_W(WA), .SCAN_DIV(SA)) dut_a (
    .clk(clk), .rst(rst_a), .sel(sel_a), .we(we_a), .data_in(data_a),
    .msg(msg_a), .sgn(sgn_a), .dot(dot_a), .busy(busy_a),
    .disp_value(val_a), .disp_select(dsel_a));

  xdisp_scan #(.N_DIGITS(NB), .BIN_W(WB), .SCAN_DIV(SB)) dut_b (
    .clk(clk), .rst(rst_b), .sel(sel_b), .we(we_b), .data_in(data_b),
    .msg(msg_b), .sgn(sgn_b), .dot(dot_b), .busy(busy_b),
    .disp_value(val_b), .disp_select(dsel_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dig(input string name, input int n, input logic [63:0] act,
                         input logic [63:0] exp);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_d%0d", name, i), {24'h0, act[8*i +: 8]}, {24'h0, exp[8*i +: 8]});
  endtask

  // Expected digit glyphs (digit i in bits 8i+7:8i) from the display rules.
  function automatic logic [63:0] glyphs(input int n, input int val, input int msg,
                                         input int sgn, input int dot);
    logic [63:0] g;
    int lim, nd, t;
    g = {8{8'hFF}};
    lim = 1;
    for (int j = 0; j < n - sgn; j++) lim = lim * 10;
    if (msg == 0 && val < lim) begin
      nd = 1;
      t  = val;
      while (t >= 10) begin t = t / 10; nd++; end
      t = val;
      for (int i = 0; i < nd; i++) begin g[8*i +: 8] = DIG[t % 10]; t = t / 10; end
      if (sgn != 0) g[8*nd +: 8] = 8'hBF;
    end else if (msg == 1) begin
      g[15:0] = 16'hC08C;
    end else if (msg == 2) begin
      g[23:0] = 24'hC188C7;
    end else begin
      g[23:0] = 24'h86AFAF;
    end
    for (int i = 0; i < n; i++) if (dot[i]) g[8*i + 7] = 1'b0;
    return g;
  endfunction

  // ---------------- model + per-cycle compare for instance A ----------------
  logic [63:0]   msh, pend;
  int            cyc, load_at, k;
  logic          m_busy;
  logic [NA-1:0] e_sel;
  logic [7:0]    e_val;
  logic          s_rst, s_sel, s_we, s_sgn;
  logic [WA-1:0] s_dat;
  logic [1:0]    s_msg;
  logic [NA-1:0] s_dot;

  task automatic mreset();
    msh = {8{8'hFF}}; cyc = 0; load_at = -1; m_busy = 1'b0;
    e_sel = '1; e_val = 8'hFF;
  endtask

  initial mreset();

  always @(posedge clk) begin
    s_rst = rst_a; s_sel = sel_a; s_we = we_a; s_dat = data_a;
    s_msg = msg_a; s_sgn = sgn_a; s_dot = dot_a;
    #1;
    if (!s_rst) begin
      mreset();
    end else begin
      cyc++;
      if (m_busy && cyc == load_at) begin
        msh = pend;
        m_busy = 1'b0;
      end else if (s_sel && s_we && !m_busy) begin
        pend = glyphs(NA, int'(s_dat), int'(s_msg), int'(s_sgn), int'(s_dot));
        load_at = cyc + WA + 1;
        m_busy = 1'b1;
      end
      if (cyc % SA == 0) begin
        k = (cyc / SA - 1) % NA;
        e_sel = ~(4'b0001 << k);
        e_val = msh[8*k +: 8];
      end
    end
    chk("mon_sel",  {28'h0, dsel_a}, {28'h0, e_sel});
    chk("mon_val",  {24'h0, val_a},  {24'h0, e_val});
    chk("mon_busy", {31'h0, busy_a}, {31'h0, m_busy});
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_a(input int val, input int msg, input int sgn, input int dot);
    @(negedge clk);
    sel_a = 1'b1; we_a = 1'b1; data_a = val[WA-1:0];
    msg_a = msg[1:0]; sgn_a = sgn[0]; dot_a = dot[NA-1:0];
    @(negedge clk);
    sel_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic wr_b(input int val, input int msg, input int sgn, input int dot);
    @(negedge clk);
    sel_b = 1'b1; we_b = 1'b1; data_b = val[WB-1:0];
    msg_b = msg[1:0]; sgn_b = sgn[0]; dot_b = dot[NB-1:0];
    @(negedge clk);
    sel_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (busy_a && n < 200) begin @(negedge clk); n++; end
    chk("idle_a", {31'h0, busy_a}, 32'h0);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (busy_b && n < 200) begin @(negedge clk); n++; end
    chk("idle_b", {31'h0, busy_b}, 32'h0);
  endtask

  // Watch the pins for (N+1) scan slots; last value seen per digit wins.
  task automatic cap_a(output logic [63:0] v);
    v = '0;
    repeat ((NA + 1) * SA) begin
      @(negedge clk);
      for (int i = 0; i < NA; i++) if (!dsel_a[i]) v[8*i +: 8] = val_a;
    end
  endtask

  task automatic cap_b(output logic [63:0] v);
    v = '0;
    repeat ((NB + 1) * SB) begin
      @(negedge clk);
      for (int i = 0; i < NB; i++) if (!dsel_b[i]) v[8*i +: 8] = val_b;
    end
  endtask

  initial begin
    int n;
    logic [63:0] v;
    rst_a = 0; sel_a = 0; we_a = 0; data_a = '0; msg_a = '0; sgn_a = 0; dot_a = '0;
    rst_b = 0; sel_b = 0; we_b = 0; data_b = '0; msg_b = '0; sgn_b = 0; dot_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel", {28'h0, dsel_a}, 32'hF);
    chk("rst_val", {24'h0, val_a}, 32'hFF);
    rst_a = 1; rst_b = 1;

    // scan start: 1110 appears after SCAN_DIV edges
    repeat (3) @(negedge clk);
    chk("scan_pre", {28'h0, dsel_a}, 32'hF);
    @(negedge clk);
    chk("scan_first", {28'h0, dsel_a}, 32'hE);
    chk("scan_blank", {24'h0, val_a}, 32'hFF);
    repeat (4) @(negedge clk);
    chk("scan_second", {28'h0, dsel_a}, 32'hD);
    repeat (12) @(negedge clk);
    chk("scan_wrap", {28'h0, dsel_a}, 32'hE);

    // sel without we
    @(negedge clk); sel_a = 1; we_a = 0; data_a = 8'd77;
    @(negedge clk); chk("sel_only", {31'h0, busy_a}, 32'h0); sel_a = 0;

    wr_a(205, 0, 0, 0); wait_a(n); chk("busy_len_a", n, 9);
    cap_a(v); chk_dig("num205", NA, v, 64'hFFA4C092);
    wr_a(7, 0, 1, 1);   wait_a(n); cap_a(v); chk_dig("neg7dp", NA, v, 64'hFFFFBF78);
    wr_a(0, 0, 0, 0);   wait_a(n); cap_a(v); chk_dig("zero", NA, v, 64'hFFFFFFC0);
    wr_a(255, 0, 1, 8); wait_a(n); cap_a(v); chk_dig("neg255", NA, v, 64'h3FA49292);
    wr_a(0, 1, 0, 0);   wait_a(n); cap_a(v); chk_dig("msg_op", NA, v, 64'hFFFFC08C);
    wr_a(0, 2, 0, 0);   wait_a(n); cap_a(v); chk_dig("msg_val", NA, v, 64'hFFC188C7);
    wr_a(0, 3, 0, 4);   wait_a(n); cap_a(v); chk_dig("msg_err", NA, v, 64'hFF06AFAF);

    // write while busy is dropped
    wr_a(42, 0, 0, 0);
    @(negedge clk);
    sel_a = 1; we_a = 1; data_a = 8'd99;
    @(negedge clk);
    sel_a = 0; we_a = 0;
    wait_a(n); cap_a(v); chk_dig("busy_drop", NA, v, 64'hFFFF99A4);

    // reset during conversion
    wr_a(123, 0, 0, 0);
    @(negedge clk);
    #2 rst_a = 0;
    #1;
    chk("midrst_sel",  {28'h0, dsel_a}, 32'hF);
    chk("midrst_val",  {24'h0, val_a},  32'hFF);
    chk("midrst_busy", {31'h0, busy_a}, 32'h0);
    @(negedge clk); rst_a = 1;
    cap_a(v); chk_dig("post_rst", NA, v, 64'hFFFFFFFF);
    wr_a(13, 0, 0, 0); wait_a(n); cap_a(v); chk_dig("num13", NA, v, 64'hFFFFF9B0);

    // instance B: 3 digits, 10-bit magnitude
    wr_b(1000, 0, 0, 0); wait_b(n); chk("busy_len_b", n, 11);
    cap_b(v); chk_dig("ovf1000", NB, v, 64'h86AFAF);
    wr_b(100, 0, 1, 0); wait_b(n); cap_b(v); chk_dig("ovf_neg100", NB, v, 64'h86AFAF);
    wr_b(999, 0, 0, 0); wait_b(n); cap_b(v); chk_dig("max999", NB, v, 64'h909090);
    wr_b(99, 0, 1, 0);  wait_b(n); cap_b(v); chk_dig("neg99", NB, v, 64'hBF9090);
    wr_b(0, 0, 1, 1);   wait_b(n); cap_b(v); chk_dig("neg0dp", NB, v, 64'hFFBF40);
    chk_dig("model_b", NB, v, glyphs(NB, 0, 0, 1, 1));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
